lsu_mem_if: RTL and testbench
=============================

# lsu_mem_if

Load/store unit memory interface for the RV32I core. Accepts one load or store command from the execute stage, checks alignment and funct3, and drives a valid/ready request plus rvalid response handshake to data memory. Store data is lane-replicated with byte enables. For loads, it selects and sign- or zero-extends the returned word into `o_ld_data`, the load-data input of the writeback select path. The core stalls on `o_lsu_busy`.

## Interface
- `TIMEOUT_CYCLES`, 64: response watchdog limit in cycles; used only when `LSU_TIMEOUT_EN` is defined.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_lsu_req`  in  1  command strobe; sampled only in IDLE.
- `i_lsu_wren`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  RV32I load/store funct3.
- `i_addr`  in  32  byte address.
- `i_st_data`  in  32  store data (rs2).
- `o_ld_data`  out  32  formatted load result; holds until the next successful load.
- `o_lsu_busy`  out  1  high in every state except IDLE.
- `o_lsu_done`  out  1  one-cycle completion pulse.
- `o_lsu_err`  out  1  high with `o_lsu_done` when the command failed.
- `o_err_cause`  out  2  01 misaligned, 10 illegal funct3, 11 timeout; valid while `o_lsu_err`=1, otherwise 00.
- `o_mem_req_valid`  out  1  memory request valid.
- `i_mem_req_ready`  in  1  memory accepts the request.
- `o_mem_addr`  out  32  word address `{i_addr[31:2],2'b00}`.
- `o_mem_we`  out  1  write request.
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `i_mem_rvalid`  in  1  response valid; also acknowledges writes.
- `i_mem_rdata`  in  32  read word.

## Operation
- **Command capture.** Command fields are registered at acceptance. Input changes after acceptance are ignored.
- **Legal funct3.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- **Misalignment.** Halfword with `addr[0]`=1, or word with `addr[1:0]`≠00.
- **States.**
  - IDLE: on `i_lsu_req`, go to ERR if the command is illegal (takes priority over misalignment) or misaligned; otherwise go to REQ.
  - REQ: `o_mem_req_valid`=1 with address/we/be/wdata stable. Go to RESP on `i_mem_req_ready`.
  - RESP: wait for `i_mem_rvalid`. For loads, capture and format `i_mem_rdata` into `o_ld_data`. Then go to DONE.
  - DONE: `o_lsu_done`=1, then go to IDLE.
  - ERR: `o_lsu_done`=1 and `o_lsu_err`=1, then go to IDLE. No memory request is issued and `o_ld_data` is unchanged.
- **Store formatting.**
  - SB: be = `4'b0001<<addr[1:0]`, wdata = `{4{st[7:0]}}`.
  - SH: be = `addr[1]?1100:0011`, wdata = `{2{st[15:0]}}`.
  - SW: be = 1111, wdata = st.
  - Loads drive be = 1111, we = 0.
- **Load formatting.**
  - Byte lane = `rdata[8*addr[1:0] +: 8]`; half lane = `rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- **Stray responses.** `i_mem_rvalid` outside RESP is ignored.
- **Reset.** Async reset in any state forces IDLE and clears all outputs and `o_ld_data` to 0. A response arriving after reset is dropped.

## Timing
- Zero-wait memory (ready and rvalid asserted on the first cycle each is possible):
  - `i_lsu_req` sampled at edge 0.
  - Cycle 1 is REQ.
  - Cycle 2 is RESP.
  - `o_lsu_done` is high in cycle 3. Latency is 3 cycles.
- Each cycle of ready or rvalid wait adds one cycle.
- Error path: `o_lsu_done`/`o_lsu_err` are high in cycle 1.
- `o_ld_data` is valid from the DONE cycle onward.
- `o_mem_req_valid` never drops before ready is seen.
- At most one transaction is outstanding. `i_lsu_req` is ignored while busy, including in the DONE cycle.
- All outputs are registered or decoded from state; there is no combinational path from memory inputs to outputs.

## Configuration
- **`LSU_TIMEOUT_EN` defined.**
  - A counter clears on entering REQ and increments each cycle in REQ or RESP.
  - When it reaches `TIMEOUT_CYCLES` without completion: go to ERR with cause 11, drop `o_mem_req_valid`, and ignore any later response.
- **`LSU_TIMEOUT_EN` undefined.** No counter is built, the block waits indefinitely, and cause 11 is never produced.

## Test plan
- **LW, zero-wait.** addr 0x100, rdata 0xDEADBEEF → mem addr 0x100, be 1111; done at cycle 3 with `o_ld_data`=0xDEADBEEF and err 0.
- **LB / LBU sign handling.** addr 0x203, rdata 0x80112233 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SH.** addr 0x12, st 0x0000ABCD, ready delayed 2 cycles → be 1100, wdata 0xABCDABCD, valid held 3 cycles, done after rvalid.
- **Error commands.**
  - LW at 0x101 → done+err, cause 01, no `o_mem_req_valid`.
  - Store with funct3 100 → cause 10.
- **Reset mid-RESP.** Then rvalid pulses → outputs 0, state IDLE, stray rvalid ignored; the next LW completes normally.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8).** rvalid withheld → err cause 11 at cycle 9 after REQ entry; a later rvalid is ignored.

Source files
------------

// File: rtl/lsu_mem_if.sv
// RV32I load/store unit memory interface: one command at a time over a valid/ready + rvalid handshake.
// Optional response watchdog is built when LSU_TIMEOUT_EN is defined.
module lsu_mem_if #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_lsu_busy,
    output logic        o_lsu_done,
    output logic        o_lsu_err,
    output logic [1:0]  o_err_cause,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_ERR} state_t;

    state_t      state;
    logic [2:0]  cmd_f3;
    logic [1:0]  cmd_lane;
    logic        illegal;
    logic        misaligned;
    logic        go_req;
    logic        tmo_hit;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] ld_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no latch is inferred.
        illegal = 1'b1;
        be_n    = 4'b1111;
        wdata_n = i_st_data;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = i_lsu_wren;
            default:                illegal = 1'b1;
        endcase
        misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
        if (i_lsu_wren) begin
            case (i_funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << i_addr[1:0];
                    wdata_n = {4{i_st_data[7:0]}};
                end
                2'b01: begin
                    be_n    = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{i_st_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign go_req = (state == S_IDLE) && i_lsu_req && !illegal && !misaligned;

    // Lane select uses the captured address bits, never the live inputs.
    always_comb begin
        ld_byte = i_mem_rdata[{cmd_lane, 3'b000} +: 8];
        ld_half = i_mem_rdata[{cmd_lane[1], 4'b0000} +: 16];
        case (cmd_f3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'b0, ld_byte};
            3'b101:  ld_fmt = {16'b0, ld_half};
            default: ld_fmt = i_mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (state == S_REQ || state == S_RESP) &&
                     (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if (go_req) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ || state == S_RESP) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    // Watchdog not built: never fires.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cmd_f3      <= 3'b000;
            cmd_lane    <= 2'b00;
            o_ld_data   <= '0;
            o_err_cause <= 2'b00;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= 4'b0000;
            o_mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_err_cause <= 2'b00;
                    if (i_lsu_req) begin
                        if (illegal) begin
                            state       <= S_ERR;
                            o_err_cause <= 2'b10;
                        end else if (misaligned) begin
                            state       <= S_ERR;
                            o_err_cause <= 2'b01;
                        end else begin
                            state       <= S_REQ;
                            cmd_f3      <= i_funct3;
                            cmd_lane    <= i_addr[1:0];
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_we    <= i_lsu_wren;
                            o_mem_be    <= be_n;
                            o_mem_wdata <= wdata_n;
                        end
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        state       <= S_ERR;
                        o_err_cause <= 2'b11;
                    end else if (i_mem_req_ready) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_mem_rvalid) begin
                        state <= S_DONE;
                        if (!o_mem_we) o_ld_data <= ld_fmt;
                    end else if (tmo_hit) begin
                        state       <= S_ERR;
                        o_err_cause <= 2'b11;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_ERR: begin
                    state       <= S_IDLE;
                    o_err_cause <= 2'b00;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_lsu_busy      = (state != S_IDLE);
    assign o_lsu_done      = (state == S_DONE) || (state == S_ERR);
    assign o_lsu_err       = (state == S_ERR);
    assign o_mem_req_valid = (state == S_REQ);

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases plus random commands against a behavioural model.
module tb_lsu_mem_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_wren;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data, ld_data;
    logic        busy, done, err;
    logic [1:0]  cause;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ld = '0;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_lsu_req(lsu_req), .i_lsu_wren(lsu_wren),
        .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data), .o_ld_data(ld_data),
        .o_lsu_busy(busy), .o_lsu_done(done), .o_lsu_err(err), .o_err_cause(cause),
        .o_mem_req_valid(mem_valid), .i_mem_req_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: error cause, byte enables, store data, load result.
    function automatic logic [1:0] m_cause(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 2'b10;
        if (f3[1:0] == 2'd1 && (a % 2) != 0) return 2'b01;
        if (f3[1:0] == 2'd2 && (a % 4) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] st);
        if (f3 == 3'd0) return (st & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (st & 32'hFFFF) * 32'h00010001;
        return st;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // One command; ready arrives after rdly wait cycles, rvalid after vdly more.
    task automatic run_cmd(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] st, input logic [31:0] rd,
                           input int rdly, input int vdly, input bit stray);
        logic [1:0] c_exp = m_cause(we, f3, a);
        int done_c = (c_exp != 2'b00) ? 1 : 3 + rdly + vdly;
        @(negedge clk);
        lsu_req = 1'b1; lsu_wren = we; funct3 = f3; addr = a; st_data = st;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(c <= done_c));
            check("done", 32'(done), 32'(c == done_c));
            check("req_valid", 32'(mem_valid), 32'(c_exp == 2'b00 && c <= 1 + rdly));
            if (c_exp == 2'b00 && c <= 1 + rdly) begin
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_be", 32'(mem_be), 32'(m_be(we, f3, a)));
                if (we) check("mem_wdata", mem_wdata, m_wdata(f3, st));
            end
            if (c == done_c) begin
                if (c_exp == 2'b00 && !we) exp_ld = m_load(f3, a, rd);
                check("err", 32'(err), 32'(c_exp != 2'b00));
                check("cause", 32'(cause), 32'(c_exp));
            end
            if (c >= done_c) check("ld_data", ld_data, exp_ld);
            // Later input changes and a request during DONE must be ignored.
            lsu_req = (c == done_c);
            lsu_wren = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; st_data = $urandom;
            mem_ready  = (c_exp == 2'b00 && c == 1 + rdly);
            mem_rvalid = (c_exp == 2'b00 && c == 2 + rdly + vdly) || (stray && c == 1);
            mem_rdata  = (c == 2 + rdly + vdly) ? rd : $urandom;
        end
        lsu_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lsu_req = 1'b0; lsu_wren = 1'b0; funct3 = 3'd0; addr = '0; st_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        #9 rst = 1'b0;

        // LW zero-wait
        run_cmd(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        check("lw_value", ld_data, 32'hDEADBEEF);
        // LB / LBU sign handling
        run_cmd(1'b0, 3'd0, 32'h203, 32'h0, 32'h80112233, 0, 0, 1'b0);
        check("lb_value", ld_data, 32'hFFFFFF80);
        run_cmd(1'b0, 3'd4, 32'h203, 32'h0, 32'h80112233, 0, 0, 1'b0);
        check("lbu_value", ld_data, 32'h00000080);
        // SH with ready delayed 2 cycles
        run_cmd(1'b1, 3'd1, 32'h12, 32'h0000ABCD, 32'h0, 2, 0, 1'b0);
        // Error commands
        run_cmd(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1);
        run_cmd(1'b1, 3'd4, 32'h200, 32'h1234, 32'h0, 0, 0, 1'b0);
        run_cmd(1'b1, 3'd2, 32'h202, 32'h1234, 32'h0, 0, 0, 1'b0);

        // Reset mid-RESP, then a stray rvalid
        @(negedge clk);
        lsu_req = 1'b1; lsu_wren = 1'b0; funct3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        lsu_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ld", ld_data, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_be", 32'(mem_be), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_cause", 32'(cause), 32'd0);
        exp_ld = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_done", 32'(done), 32'd0);
        check("stray_ld", ld_data, 32'd0);
        run_cmd(1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: ready given, rvalid withheld
        @(negedge clk);
        lsu_req = 1'b1; lsu_wren = 1'b0; funct3 = 3'd2; addr = 32'h40;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            lsu_req = 1'b0;
            check("tmo_done", 32'(done), 32'(c == 9));
            check("tmo_busy", 32'(busy), 32'(c <= 9));
            if (c == 9) begin
                check("tmo_err", 32'(err), 32'd1);
                check("tmo_cause", 32'(cause), 32'd3);
                check("tmo_valid", 32'(mem_valid), 32'd0);
            end
            if (c == 11) check("tmo_ld", ld_data, exp_ld);
            mem_ready  = (c == 1);
            mem_rvalid = (c == 10);
        end
        mem_rvalid = 1'b0;
`endif

        // Random commands, biased toward aligned addresses
        for (int n = 0; n < 40; n++) begin
            logic        we = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
            run_cmd(we, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
